// File: rtl/n_lane_transpose_buf_pkg.sv
// tbuf_pkg: shared defaults and sizing helpers for the n-lane transpose buffer
package tbuf_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BLK_DIM = 8;
  localparam int DEF_LANES = 2;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return (r < 1) ? 1 : r;
  endfunction
  function automatic int beats_per_blk(input int dim, input int lanes);
    return dim * dim / lanes;
  endfunction
endpackage

// File: rtl/n_lane_transpose_buf_if.sv
// n_lane_transpose_buf_if: write/read beat bus of the transpose buffer
// master: drives wen/wdata/rready, observes wready/rvalid/rdata/rsync/rlast
// slave: the buffer side
interface n_lane_transpose_buf_if
  import tbuf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES = DEF_LANES
);
  logic wen;
  logic wready;
  logic [LANES*DATA_WIDTH-1:0] wdata;
  logic rvalid;
  logic rready;
  logic rsync;
  logic rlast;
  logic [LANES*DATA_WIDTH-1:0] rdata;
  modport master (output wen, wdata, rready, input wready, rvalid, rdata, rsync, rlast);
  modport slave (input wen, wdata, rready, output wready, rvalid, rdata, rsync, rlast);
endinterface

// File: rtl/n_lane_transpose_buf_bank.sv
// tbuf_bank: one N x N pixel block, LANES-wide row write port, LANES-wide column read port
// Ports: clk, we, wrow/wcol (write row, first column), wdata, rrow/rcol (first row, read column), rdata
module tbuf_bank
  import tbuf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BLK_DIM = DEF_BLK_DIM,
  parameter int LANES = DEF_LANES
)(
  input logic clk,
  input logic we,
  input logic [clog2(BLK_DIM)-1:0] wrow,
  input logic [clog2(BLK_DIM)-1:0] wcol,
  input logic [LANES*DATA_WIDTH-1:0] wdata,
  input logic [clog2(BLK_DIM)-1:0] rrow,
  input logic [clog2(BLK_DIM)-1:0] rcol,
  output logic [LANES*DATA_WIDTH-1:0] rdata
);
  localparam int IW = clog2(BLK_DIM);
  logic [DATA_WIDTH-1:0] mem [BLK_DIM][BLK_DIM];
  always_ff @(posedge clk)
    if (we)
      for (int l = 0; l < LANES; l++)
        mem[wrow][wcol + IW'(l)] <= wdata[l*DATA_WIDTH +: DATA_WIDTH];
  for (genvar g = 0; g < LANES; g++) begin : g_rd
    assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = mem[rrow + IW'(g)][rcol];
  end
endmodule

// File: rtl/n_lane_transpose_buf.sv
// n_lane_transpose_buf: ping-pong N x N block transposer, row-major in, column-major out, LANES pixels per beat
// Ports: i_clk, i_resetn (async active-low), bus (slave: wen/wdata/wready in, rvalid/rready/rdata/rsync/rlast out)
// Optional TBUF_DROP_CNT_EN: adds drop_cnt[15:0], saturating count of cycles with wen && !wready
module n_lane_transpose_buf
  import tbuf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BLK_DIM = DEF_BLK_DIM,
  parameter int LANES = DEF_LANES
)(
  input logic i_clk,
  input logic i_resetn,
  n_lane_transpose_buf_if.slave bus
`ifdef TBUF_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);
  localparam int BEATS = beats_per_blk(BLK_DIM, LANES);
  localparam int CW = clog2(BEATS);
  localparam int IW = clog2(BLK_DIM);
  if (BLK_DIM % LANES != 0) begin : g_bad_lanes
    $error("LANES must divide BLK_DIM");
  end
  logic [1:0] full;
  logic wbank, rbank;
  logic [CW-1:0] wcnt, rcnt;
  logic whs, rhs, wend, rend;
  logic [1:0] wset, rclr;
  logic [IW-1:0] wrow, wcol, rrow, rcol;
  logic [LANES*DATA_WIDTH-1:0] bank_rd [2];
  assign bus.wready = !full[wbank];
  assign bus.rvalid = full[rbank];
  assign whs = bus.wen && bus.wready;
  assign rhs = bus.rvalid && bus.rready;
  assign wend = whs && wcnt == CW'(BEATS - 1);
  assign rend = rhs && rcnt == CW'(BEATS - 1);
  assign wset = wend ? (wbank ? 2'b10 : 2'b01) : 2'b00;
  assign rclr = rend ? (rbank ? 2'b10 : 2'b01) : 2'b00;
  // write walks row-major, read walks column-major over the same linear beat index
  assign wrow = IW'((int'(wcnt) * LANES) / BLK_DIM);
  assign wcol = IW'((int'(wcnt) * LANES) % BLK_DIM);
  assign rrow = IW'((int'(rcnt) * LANES) % BLK_DIM);
  assign rcol = IW'((int'(rcnt) * LANES) / BLK_DIM);
  // gated so rdata reads 0 out of reset even though storage is never cleared
  assign bus.rdata = bus.rvalid ? bank_rd[rbank] : '0;
  assign bus.rsync = bus.rvalid && rcnt == '0;
  assign bus.rlast = bus.rvalid && rcnt == CW'(BEATS - 1);
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      full <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      wcnt <= '0;
      rcnt <= '0;
    end else begin
      full <= (full | wset) & ~rclr;
      if (whs) wcnt <= wend ? '0 : wcnt + CW'(1);
      if (rhs) rcnt <= rend ? '0 : rcnt + CW'(1);
      if (wend) wbank <= !wbank;
      if (rend) rbank <= !rbank;
    end
  end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    tbuf_bank #(.DATA_WIDTH(DATA_WIDTH), .BLK_DIM(BLK_DIM), .LANES(LANES)) u_bank (
      .clk(i_clk),
      .we(whs && wbank == 1'(b)),
      .wrow(wrow),
      .wcol(wcol),
      .wdata(bus.wdata),
      .rrow(rrow),
      .rcol(rcol),
      .rdata(bank_rd[b])
    );
  end
`ifdef TBUF_DROP_CNT_EN
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) drop_cnt <= '0;
    else if (bus.wen && !bus.wready && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_n_lane_transpose_buf.sv
// tb_n_lane_transpose_buf: scoreboard bench for the transpose buffer at DATA_WIDTH=8, BLK_DIM=8, LANES=2
module tb_n_lane_transpose_buf;
  localparam int DW = 8;
  localparam int N = 8;
  localparam int L = 2;
  localparam int BEATS = N * N / L;
  typedef struct {
    logic [L*DW-1:0] d;
    logic s;
    logic l;
  } exp_t;
  logic i_clk = 1'b0;
  logic i_resetn = 1'b0;
`ifdef TBUF_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int rd_first = -1;
  int rd_last = -1;
  int wr_rise = -1;
  bit track_rise = 1'b0;
  logic last_wready;
  exp_t q[$];
  logic [L*DW-1:0] rd_log [256];
  n_lane_transpose_buf_if #(.DATA_WIDTH(DW), .LANES(L)) bus ();
  n_lane_transpose_buf #(.DATA_WIDTH(DW), .BLK_DIM(N), .LANES(L)) dut (
    .i_clk(i_clk),
    .i_resetn(i_resetn),
    .bus(bus)
`ifdef TBUF_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic logic [L*DW-1:0] exp_beat(input int base, input int k);
    logic [L*DW-1:0] r;
    for (int l = 0; l < L; l++) r[l*DW +: DW] = DW'(base + ((k * L) % N + l) * N + (k * L) / N);
    return r;
  endfunction
  task automatic push_block(input int base);
    for (int k = 0; k < BEATS; k++) q.push_back('{exp_beat(base, k), k == 0, k == BEATS - 1});
  endtask
  // scoreboard monitor: every rvalid cycle must match the head of the queue, popped on handshake
  always @(negedge i_clk) begin
    if (!i_resetn) check("rvalid_in_reset", int'(bus.rvalid), 0);
    else if (bus.rvalid) begin
      if (q.size() == 0) check("spurious_rvalid", 1, 0);
      else begin
        check("rdata", int'(bus.rdata), int'(q[0].d));
        check("rsync", int'(bus.rsync), int'(q[0].s));
        check("rlast", int'(bus.rlast), int'(q[0].l));
        if (bus.rready) begin
          void'(q.pop_front());
          if (rd_cnt < 256) rd_log[rd_cnt] = bus.rdata;
          if (rd_first < 0) rd_first = cyc;
          rd_last = cyc;
          rd_cnt++;
        end
      end
    end else begin
      check("rsync_idle", int'(bus.rsync), 0);
      check("rlast_idle", int'(bus.rlast), 0);
    end
    if (track_rise && bus.wready && wr_rise < 0) wr_rise = cyc;
  end
  // drives one beat starting just after a rising edge, returns just after the next one
  task automatic wr(input logic [L*DW-1:0] d);
    bus.wen = 1'b1;
    bus.wdata = d;
    @(negedge i_clk);
    last_wready = bus.wready;
    @(posedge i_clk);
    #1;
    bus.wen = 1'b0;
  endtask
  task automatic write_block(input int base, input bit strict);
    logic [L*DW-1:0] d;
    int tries;
    for (int k = 0; k < BEATS; k++) begin
      for (int l = 0; l < L; l++) d[l*DW +: DW] = DW'(base + k * L + l);
      tries = 0;
      do begin
        wr(d);
        tries++;
      end while (!last_wready && tries < 200);
      if (strict) check("wready_stream", int'(last_wready), 1);
      else if (!last_wready) check("write_timeout", 0, 1);
    end
  endtask
  task automatic wait_drain();
    for (int i = 0; i < 1000 && q.size() != 0; i++) @(posedge i_clk);
    #1;
    check("drain", q.size(), 0);
  endtask
  task automatic reset_stats();
    rd_cnt = 0;
    rd_first = -1;
    rd_last = -1;
  endtask
  initial begin
    int n, rise_cyc;
    bus.wen = 1'b0;
    bus.wdata = '0;
    bus.rready = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_wready", int'(bus.wready), 1);
    check("reset_rvalid", int'(bus.rvalid), 0);
    check("reset_rsync", int'(bus.rsync), 0);
    check("reset_rlast", int'(bus.rlast), 0);
    check("reset_rdata", int'(bus.rdata), 0);
    @(posedge i_clk);
    #1;
    i_resetn = 1'b1;
    // single block transpose
    reset_stats();
    write_block(0, 1'b1);
    push_block(0);
    @(negedge i_clk);
    check("rvalid_latency", int'(bus.rvalid), 1);
    wait_drain();
    check("blk_beats", rd_cnt, 32);
    check("beat0", int'(rd_log[0]), 32'h0800);
    check("beat1", int'(rd_log[1]), 32'h1810);
    check("beat4", int'(rd_log[4]), 32'h0901);
    check("beat31", int'(rd_log[31]), 32'h3F37);
    // four back-to-back blocks
    reset_stats();
    for (int b = 0; b < 4; b++) begin
      write_block(64 * b, 1'b1);
      push_block(64 * b);
    end
    wait_drain();
    check("stream_beats", rd_cnt, 128);
    check("stream_span", rd_last - rd_first, 127);
    // backpressure: fill both banks, drop one beat, then drain
    reset_stats();
    bus.rready = 1'b0;
    write_block(0, 1'b0);
    push_block(0);
    write_block(64, 1'b0);
    push_block(64);
    @(negedge i_clk);
    check("wready_full", int'(bus.wready), 0);
    @(posedge i_clk);
    #1;
    wr(16'hAAAA);
    check("dropped_beat", int'(last_wready), 0);
`ifdef TBUF_DROP_CNT_EN
    check("drop_cnt_one", int'(drop_cnt), 1);
`endif
    wr_rise = -1;
    track_rise = 1'b1;
    rise_cyc = cyc;
    bus.rready = 1'b1;
    wait_drain();
    track_rise = 1'b0;
    check("bp_beats", rd_cnt, 64);
    check("wready_rise", wr_rise, rise_cyc + 32);
    // alternating rready: held output while stalled, each beat exactly once
    reset_stats();
    bus.rready = 1'b0;
    write_block(128, 1'b1);
    push_block(128);
    for (n = 0; n < 200 && q.size() != 0; n++) begin
      bus.rready = !bus.rready;
      @(posedge i_clk);
      #1;
    end
    bus.rready = 1'b1;
    check("stall_beats", rd_cnt, 32);
    check("stall_cycles", n, 63);
    // reset in the middle of a block discards the partial block
    reset_stats();
    for (int k = 0; k < 10; k++) wr(16'h5555);
    i_resetn = 1'b0;
    @(negedge i_clk);
    check("midrst_wready", int'(bus.wready), 1);
    check("midrst_rdata", int'(bus.rdata), 0);
`ifdef TBUF_DROP_CNT_EN
    check("drop_cnt_reset", int'(drop_cnt), 0);
`endif
    repeat (2) @(posedge i_clk);
    #1;
    i_resetn = 1'b1;
    write_block(192, 1'b1);
    push_block(192);
    wait_drain();
    check("midrst_beats", rd_cnt, 32);
    repeat (4) @(posedge i_clk);
    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
